emu_run_ctrl: RTL and testbench

EMU_RUN_CTRL -- requirements
Module: emu_run_ctrl

---
 rtl/emu_run_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_emu_run_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/emu_run_ctrl.sv
// emu_run_ctrl: run/halt/step controller for an emulated-time engine.
//
// Handshake: a command is taken on any rising clk_sys edge where cmd_valid
// and cmd_ready are both high; cmd_ready is low only while a single STEP is
// in flight. cmd_op is sampled in the same cycle as the handshake.
//
// A set of time triggers watches time_curr on every time_valid. Each armed
// trigger fires once when time_curr reaches its threshold. Firing sets a
// sticky flag, emits a one-cycle pulse, bumps a saturating counter and, in
// halt mode while running or stepping, forces the controller into HALT.
// An optional absolute stop time halts in the same way. CLEAR re-arms all
// triggers and wipes the flags, counter and halt causes without touching
// the run state.
//
// All outputs come straight from flops; the debug view of the FSM is the
// state output itself.
module emu_run_ctrl #(
  parameter int TIME_WIDTH = 48,
  parameter int N_TRIG     = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic [TIME_WIDTH-1:0]        time_curr,
  input  logic                         time_valid,
  input  logic                         cmd_valid,
  input  logic [1:0]                   cmd_op,
  output logic                         cmd_ready,
  input  logic [N_TRIG*TIME_WIDTH-1:0] trig_time,
  input  logic [N_TRIG*2-1:0]          trig_mode,
  input  logic                         stop_en,
  input  logic [TIME_WIDTH-1:0]        stop_time,
  output logic                         emu_en,
  output logic [1:0]                   state,
  output logic [N_TRIG-1:0]            trig_flag,
  output logic [N_TRIG-1:0]            trig_pulse,
  output logic [N_TRIG:0]              halt_cause,
  output logic [CNT_WIDTH-1:0]         trig_count
);

  // FSM encodings (match the state output)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_STEP = 2'd3;

  // Command opcodes
  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_HALT  = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  // Trigger modes
  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_HALT = 2'd3;

  // Width wide enough to hold counter plus a full popcount without wrap
  localparam int POP_W = $clog2(N_TRIG + 1);
  localparam int SUM_W = CNT_WIDTH + POP_W + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  // Registered state
  logic [1:0]           state_q,      state_d;
  logic                 emu_en_q,     emu_en_d;
  logic                 cmd_ready_q,  cmd_ready_d;
  logic [N_TRIG-1:0]    armed_q,      armed_d;
  logic [N_TRIG-1:0]    trig_flag_q,  trig_flag_d;
  logic [N_TRIG-1:0]    trig_pulse_q, trig_pulse_d;
  logic [N_TRIG:0]      halt_cause_q, halt_cause_d;
  logic [CNT_WIDTH-1:0] trig_count_q, trig_count_d;

  // Decoded command strobes
  logic cmd_acc;
  logic acc_run;
  logic acc_halt;
  logic acc_step;
  logic acc_clear;

  // Trigger evaluation results
  logic [N_TRIG-1:0] fire;
  logic [N_TRIG-1:0] trig_halt;
  logic [POP_W-1:0]  fire_cnt;
  logic              active;
  logic              stop_hit;
  logic              halt_cond;

  // Saturating counter arithmetic
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_WIDTH-1:0] cnt_base;

  // Decode an accepted command into one-hot strobes
  always_comb begin
    cmd_acc   = cmd_valid & cmd_ready_q;
    acc_run   = cmd_acc & (cmd_op == OP_RUN);
    acc_halt  = cmd_acc & (cmd_op == OP_HALT);
    acc_step  = cmd_acc & (cmd_op == OP_STEP);
    acc_clear = cmd_acc & (cmd_op == OP_CLEAR);
  end

  // Compare live thresholds against the advancing time and find halt sources
  always_comb begin
    fire      = '0;
    trig_halt = '0;
    fire_cnt  = '0;
    active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    for (int i = 0; i < N_TRIG; i++) begin
      fire[i] = time_valid && armed_q[i] &&
                (trig_mode[2*i +: 2] != MODE_OFF) &&
                (time_curr >= trig_time[i*TIME_WIDTH +: TIME_WIDTH]);
      trig_halt[i] = active && fire[i] && (trig_mode[2*i +: 2] == MODE_HALT);
      fire_cnt = fire_cnt + POP_W'(fire[i]);
    end
    stop_hit  = active && time_valid && stop_en && (time_curr >= stop_time);
    halt_cond = (|trig_halt) || stop_hit;
  end

  // Next-state logic; a halt condition outranks any same-cycle command
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (acc_run)       state_d = ST_RUN;
        else if (acc_step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (acc_halt) state_d = ST_HALT;
      end
      ST_STEP: begin
        // exactly one time advance is allowed through
        if (time_valid) state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (halt_cond) state_d = ST_HALT;
    emu_en_d    = (state_d == ST_RUN) || (state_d == ST_STEP);
    cmd_ready_d = (state_d != ST_STEP);
  end

  // Trigger bookkeeping: arming, flags, pulses, causes and the counter
  always_comb begin
    armed_d      = (acc_clear ? {N_TRIG{1'b1}} : armed_q) & ~fire;
    trig_flag_d  = (acc_clear ? '0 : trig_flag_q) | fire;
    trig_pulse_d = fire;
    // resuming wipes old causes; causes raised this same cycle still land
    halt_cause_d = (acc_clear || acc_run || acc_step) ? '0 : halt_cause_q;
    halt_cause_d = halt_cause_d | {stop_hit, trig_halt};
    cnt_base     = acc_clear ? '0 : trig_count_q;
    cnt_sum      = SUM_W'(cnt_base) + SUM_W'(fire_cnt);
    trig_count_d = (cnt_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      emu_en_q     <= 1'b0;
      cmd_ready_q  <= 1'b1;
      armed_q      <= {N_TRIG{1'b1}};
      trig_flag_q  <= '0;
      trig_pulse_q <= '0;
      halt_cause_q <= '0;
      trig_count_q <= '0;
    end else begin
      state_q      <= state_d;
      emu_en_q     <= emu_en_d;
      cmd_ready_q  <= cmd_ready_d;
      armed_q      <= armed_d;
      trig_flag_q  <= trig_flag_d;
      trig_pulse_q <= trig_pulse_d;
      halt_cause_q <= halt_cause_d;
      trig_count_q <= trig_count_d;
    end
  end

  assign state      = state_q;
  assign emu_en     = emu_en_q;
  assign cmd_ready  = cmd_ready_q;
  assign trig_flag  = trig_flag_q;
  assign trig_pulse = trig_pulse_q;
  assign halt_cause = halt_cause_q;
  assign trig_count = trig_count_q;

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Directed bench for emu_run_ctrl. A small counter width makes counter
// saturation reachable with four triggers.
module tb_emu_run_ctrl;

  localparam int TW = 48;
  localparam int NT = 4;
  localparam int CW = 2;

  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] SR = 2'd1;
  localparam logic [1:0] SH = 2'd2;
  localparam logic [1:0] SS = 2'd3;

  localparam logic [1:0] OR = 2'd0;
  localparam logic [1:0] OH = 2'd1;
  localparam logic [1:0] OS = 2'd2;
  localparam logic [1:0] OC = 2'd3;

  typedef struct {
    logic          rst;
    logic          cv;
    logic [1:0]    op;
    logic          tv;
    logic [TW-1:0] tc;
    logic [7:0]    mode;
    logic          sen;
    logic [1:0]    st;
    logic [3:0]    flag;
    logic [3:0]    pulse;
    logic [4:0]    cause;
    logic [1:0]    cnt;
  } vec_t;

  // clock / reset
  logic clk_sys = 1'b0;
  logic rst = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic [TW-1:0]    time_curr = '0;
  logic             time_valid = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'd0;
  logic             cmd_ready;
  logic [NT*TW-1:0] trig_time = {48'd3000, 48'd500, 48'd500, 48'd1000};
  logic [NT*2-1:0]  trig_mode = '0;
  logic             stop_en = 1'b0;
  logic [TW-1:0]    stop_time = 48'd2000;
  logic             emu_en;
  logic [1:0]       state;
  logic [NT-1:0]    trig_flag;
  logic [NT-1:0]    trig_pulse;
  logic [NT:0]      halt_cause;
  logic [CW-1:0]    trig_count;

  emu_run_ctrl #(.TIME_WIDTH(TW), .N_TRIG(NT), .CNT_WIDTH(CW)) dut (
    .clk_sys(clk_sys), .rst(rst), .time_curr(time_curr), .time_valid(time_valid),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .trig_time(trig_time), .trig_mode(trig_mode), .stop_en(stop_en),
    .stop_time(stop_time), .emu_en(emu_en), .state(state),
    .trig_flag(trig_flag), .trig_pulse(trig_pulse), .halt_cause(halt_cause),
    .trig_count(trig_count)
  );

  int total = 0;
  int bad = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic cv, input logic [1:0] op,
                              input logic tv, input logic [TW-1:0] tc,
                              input logic [7:0] mode, input logic sen,
                              input logic [1:0] st, input logic [3:0] flag,
                              input logic [3:0] pulse, input logic [4:0] cause,
                              input logic [1:0] cnt);
    vec_t v;
    v.rst = r; v.cv = cv; v.op = op; v.tv = tv; v.tc = tc; v.mode = mode;
    v.sen = sen; v.st = st; v.flag = flag; v.pulse = pulse; v.cause = cause;
    v.cnt = cnt;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  // driver: set inputs on the falling edge, let one rising edge pass
  task automatic drive(input logic r, input logic cv, input logic [1:0] op,
                       input logic tv, input logic [TW-1:0] tc,
                       input logic [7:0] mode, input logic sen);
    @(negedge clk_sys);
    rst = r; cmd_valid = cv; cmd_op = op; time_valid = tv; time_curr = tc;
    trig_mode = mode; stop_en = sen;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_state(input int row, input logic [1:0] st);
    check("state", row, 64'(state), 64'(st));
    check("emu_en", row, 64'(emu_en), 64'((st == SR) || (st == SS)));
    check("cmd_ready", row, 64'(cmd_ready), 64'(st != SS));
  endtask

  initial begin
    // stimulus table: inputs, then expected outputs after the next edge
    tbl.push_back(mk(1, 0, OR, 0,    0, 8'h14, 0, SI, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 1, OR, 0,    0, 8'h14, 0, SR, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 0, OR, 1,  490, 8'h14, 0, SR, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 0, OR, 1,  500, 8'h14, 0, SR, 4'h6, 4'h6, 5'h00, 2'd2));
    tbl.push_back(mk(0, 0, OR, 0,  500, 8'h14, 0, SR, 4'h6, 4'h0, 5'h00, 2'd2));
    tbl.push_back(mk(0, 1, OC, 0,  500, 8'h03, 0, SR, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 0, OR, 1,  990, 8'h03, 0, SR, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 0, OR, 1, 1000, 8'h03, 0, SH, 4'h1, 4'h1, 5'h01, 2'd1));
    tbl.push_back(mk(0, 0, OR, 1, 1010, 8'h03, 0, SH, 4'h1, 4'h0, 5'h01, 2'd1));
    tbl.push_back(mk(0, 1, OS, 0, 1010, 8'h03, 0, SS, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 0, OR, 0, 1010, 8'h03, 0, SS, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 1, OR, 0, 1010, 8'h03, 0, SS, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 0, OR, 1, 1020, 8'h03, 0, SH, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 0, OR, 1, 1030, 8'h03, 0, SH, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 0, OR, 1, 1040, 8'h03, 0, SH, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 1, OR, 0, 1040, 8'h00, 0, SR, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 0, OR, 1, 1990, 8'h00, 1, SR, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 0, OR, 1, 2000, 8'h00, 1, SH, 4'h1, 4'h0, 5'h10, 2'd1));
    tbl.push_back(mk(0, 1, OR, 0, 2000, 8'h00, 1, SR, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(0, 0, OR, 1, 2010, 8'h00, 1, SH, 4'h1, 4'h0, 5'h10, 2'd1));
    tbl.push_back(mk(0, 1, OC, 0, 2010, 8'h00, 0, SH, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 0, OR, 1, 2020, 8'h55, 0, SH, 4'h7, 4'h7, 5'h00, 2'd3));
    tbl.push_back(mk(0, 0, OR, 1, 3000, 8'h55, 0, SH, 4'hF, 4'h8, 5'h00, 2'd3));
    tbl.push_back(mk(0, 1, OC, 0, 3000, 8'h55, 0, SH, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 0, OR, 1, 3010, 8'h55, 0, SH, 4'hF, 4'hF, 5'h00, 2'd3));
    tbl.push_back(mk(0, 0, OR, 1,  100, 8'h55, 0, SH, 4'hF, 4'h0, 5'h00, 2'd3));
    tbl.push_back(mk(0, 1, OC, 0,  100, 8'h03, 0, SH, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 1, OR, 0,  100, 8'h03, 0, SR, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 1, OR, 1, 1000, 8'h03, 0, SH, 4'h1, 4'h1, 5'h01, 2'd1));
    tbl.push_back(mk(0, 1, OC, 0, 1000, 8'h03, 0, SH, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 1, OR, 0, 1000, 8'h03, 0, SR, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 1, OH, 1, 1000, 8'h03, 0, SH, 4'h1, 4'h1, 5'h01, 2'd1));
    tbl.push_back(mk(0, 1, OC, 0, 1000, 8'h03, 0, SH, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 1, OS, 0, 1000, 8'h03, 0, SS, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 0, OR, 1, 1000, 8'h03, 0, SH, 4'h1, 4'h1, 5'h01, 2'd1));
    tbl.push_back(mk(0, 1, OS, 0, 1000, 8'h03, 0, SS, 4'h1, 4'h0, 5'h00, 2'd1));
    tbl.push_back(mk(1, 1, OR, 1, 1000, 8'h55, 0, SI, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 1, OH, 0, 1000, 8'h55, 0, SI, 4'h0, 4'h0, 5'h00, 2'd0));
    tbl.push_back(mk(0, 0, OR, 1,  600, 8'h55, 0, SI, 4'h6, 4'h6, 5'h00, 2'd2));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].cv, tbl[i].op, tbl[i].tv, tbl[i].tc, tbl[i].mode, tbl[i].sen);
      check_state(i, tbl[i].st);
      check("trig_flag", i, 64'(trig_flag), 64'(tbl[i].flag));
      check("trig_pulse", i, 64'(trig_pulse), 64'(tbl[i].pulse));
      check("halt_cause", i, 64'(halt_cause), 64'(tbl[i].cause));
      check("trig_count", i, 64'(trig_count), 64'(tbl[i].cnt));
    end

    // long STEP: held RUN command is refused until the single advance lands
    drive(0, 1, OS, 0, 600, 8'h00, 0);
    check_state(100, SS);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, OR, 0, 600, 8'h00, 0);
      check_state(101 + k, SS);
    end
    drive(0, 1, OR, 1, 700, 8'h00, 0);
    check_state(110, SH);
    check("trig_count", 110, 64'(trig_count), 64'd2);
    drive(0, 1, OR, 0, 700, 8'h00, 0);
    check_state(111, SR);
    drive(0, 0, OR, 0, 700, 8'h00, 0);
    check_state(112, SR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
